// File: rtl/jpeg_pkg.sv
// Shared constants, types and the zigzag-to-raster map for the JPEG quantize/zigzag stage.
package jpeg_pkg;
  localparam int COEF_W  = 8;
  localparam int RECIP_W = 17;
  localparam int FRAC_W  = 16;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [RECIP_W-1:0]       recip_t;
  typedef logic [5:0]               idx_t;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  // Zigzag index k -> raster position (row*8+col)
  localparam idx_t ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/jpeg_quant_zigzag_if.sv
// Block input, table write and coefficient output stream of the quantize/zigzag stage.
interface jpeg_quant_zigzag_if;
  import jpeg_pkg::*;

  logic                  blk_valid;
  logic                  blk_ready;
  logic [64*COEF_W-1:0]  blk_coef;
  logic                  qt_wr_en;
  idx_t                  qt_addr;
  recip_t                qt_data;
  logic                  out_valid;
  logic                  out_ready;
  coef_t                 out_coef;
  idx_t                  out_idx;
  logic                  out_last;

  modport master (
    output blk_valid, blk_coef, qt_wr_en, qt_addr, qt_data, out_ready,
    input  blk_ready, out_valid, out_coef, out_idx, out_last
  );

  modport slave (
    input  blk_valid, blk_coef, qt_wr_en, qt_addr, qt_data, out_ready,
    output blk_ready, out_valid, out_coef, out_idx, out_last
  );
endinterface

// File: rtl/jpeg_quant_mul.sv
// Sign-magnitude multiply by a fixed-point reciprocal, round half away from zero, saturate.
module jpeg_quant_mul
  import jpeg_pkg::*;
(
  input  coef_t  coef,
  input  recip_t recip,
  output coef_t  q
);
  localparam int MAG_W  = COEF_W + 1;
  localparam int PROD_W = MAG_W + RECIP_W;
  localparam int R_W    = PROD_W - FRAC_W;
  localparam coef_t      Q_MAX = coef_t'((2 ** (COEF_W - 1)) - 1);
  localparam coef_t      Q_MIN = coef_t'(-(2 ** (COEF_W - 1)));
  localparam logic [R_W-1:0] R_POS_LIM = R_W'((2 ** (COEF_W - 1)) - 1);
  localparam logic [R_W-1:0] R_NEG_LIM = R_W'(2 ** (COEF_W - 1));

  logic                    neg;
  logic signed [MAG_W-1:0] ext;
  logic [MAG_W-1:0]        mag;
  logic [PROD_W-1:0]       prod;
  logic [PROD_W-1:0]       rnd;
  logic [R_W-1:0]          r;
  logic [R_W-1:0]          r_neg;

  always_comb begin
    neg   = coef[COEF_W-1];
    ext   = {coef[COEF_W-1], coef};
    mag   = neg ? $unsigned(-ext) : $unsigned(ext);
    prod  = PROD_W'(mag) * PROD_W'(recip);
    // Rounding on the magnitude makes ties go away from zero for both signs
    rnd   = prod + (PROD_W'(1) << (FRAC_W - 1));
    r     = rnd[PROD_W-1:FRAC_W];
    r_neg = -r;
    q     = '0;
    if (neg) begin
      q = (r > R_NEG_LIM) ? Q_MIN : coef_t'(r_neg[COEF_W-1:0]);
    end else begin
      q = (r > R_POS_LIM) ? Q_MAX : coef_t'(r[COEF_W-1:0]);
    end
  end
endmodule

// File: rtl/jpeg_quant_zigzag.sv
// Captures an 8x8 raster block, quantizes by a reciprocal table and streams it in zigzag order.
module jpeg_quant_zigzag
  import jpeg_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  jpeg_quant_zigzag_if.slave  bus
);
  coef_t  buffer  [64];
  recip_t table_q [64];
  state_t state;
  idx_t   k;
  idx_t   raster;
  coef_t  q;
  logic   accept;
  logic   advance;

  assign raster  = ZIGZAG[k];
  assign accept  = (state == IDLE) && bus.blk_valid && bus.blk_ready;
  assign advance = (state == BUSY) && (!bus.out_valid || bus.out_ready);

  jpeg_quant_mul u_mul (
    .coef  (buffer[raster]),
    .recip (table_q[raster]),
    .q     (q)
  );

  // Table and block storage carry no reset; software reloads the table
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.qt_wr_en) begin
      table_q[bus.qt_addr] <= bus.qt_data;
    end
    if (accept) begin
      for (int unsigned p = 0; p < 64; p++) begin
        buffer[p] <= bus.blk_coef[p*COEF_W +: COEF_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      k             <= '0;
      bus.blk_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_coef  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.blk_ready <= 1'b1;
          if (accept) begin
            bus.blk_ready <= 1'b0;
            k             <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (advance) begin
            bus.out_coef  <= q;
            bus.out_idx   <= k;
            bus.out_last  <= (k == 6'd63);
            bus.out_valid <= 1'b1;
            k             <= k + idx_t'(1);
            if (k == 6'd63) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.blk_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Directed bench for jpeg_quant_zigzag: ordering, rounding, saturation, backpressure, table gating, reset.
module tb_jpeg_quant_zigzag;
  import jpeg_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  jpeg_quant_zigzag_if bus ();

  jpeg_quant_zigzag dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int zz     [64];
  int shadow [64];
  int blk    [64];
  int got    [64];
  int expq   [64];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qmodel(input int c, input int recip);
    int       m;
    longint   p;
    int       r;
    int       v;
    m = (c < 0) ? -c : c;
    p = longint'(m) * longint'(recip) + 64'sd32768;
    r = int'(p >>> 16);
    v = (c < 0) ? -r : r;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic write_qt(input int a, input int d);
    @(negedge clock);
    bus.qt_wr_en = 1'b1;
    bus.qt_addr  = 6'(a);
    bus.qt_data  = 17'(d);
    shadow[a]    = d;
    @(negedge clock);
    bus.qt_wr_en = 1'b0;
  endtask

  // Accept one block and consume its stream; optional stall, busy-time write, accept-time write, reset.
  task automatic run_block(input int stall_idx, input int busy_wr, input int acc_addr,
                           input int acc_data, input int rst_idx, input bit chk_lat);
    int cyc;
    int beats;
    int first;
    logic [7:0] b;
    cyc = 0;
    @(negedge clock);
    while (!bus.blk_ready && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    if (!bus.blk_ready) begin
      check("blk_ready_wait", 0, 1);
      return;
    end
    if (acc_addr >= 0) begin
      bus.qt_wr_en     = 1'b1;
      bus.qt_addr      = 6'(acc_addr);
      bus.qt_data      = 17'(acc_data);
      shadow[acc_addr] = acc_data;
    end
    for (int p = 0; p < 64; p++) begin
      b = 8'(blk[p]);
      bus.blk_coef[p*8 +: 8] = b;
      expq[p] = qmodel(blk[p], shadow[p]);
      got[p]  = 999;
    end
    bus.blk_valid = 1'b1;
    @(negedge clock);
    bus.blk_valid = 1'b0;
    bus.qt_wr_en  = 1'b0;
    for (int w = 0; w < 16; w++) bus.blk_coef[w*32 +: 32] = $urandom();
    check("valid_after_accept", int'(bus.out_valid), 0);
    cyc   = 1;
    beats = 0;
    first = -1;
    while (beats < 64 && cyc < 400) begin
      @(negedge clock);
      cyc++;
      bus.qt_wr_en = 1'b0;
      if (bus.out_valid) begin
        if (first < 0) begin
          first = cyc;
          if (chk_lat) check("first_valid_latency", cyc, 2);
        end
        check("out_idx", int'(bus.out_idx), beats);
        check("out_last", int'(bus.out_last), int'(beats == 63));
        check("out_coef", int'($signed(bus.out_coef)), expq[zz[beats]]);
        got[zz[beats]] = int'($signed(bus.out_coef));
        if (beats == rst_idx) begin
          #2 reset_n = 1'b0;
          #1;
          check("rst_out_valid", int'(bus.out_valid), 0);
          check("rst_blk_ready", int'(bus.blk_ready), 0);
          check("rst_out_idx", int'(bus.out_idx), 0);
          @(negedge clock);
          reset_n = 1'b1;
          #1 check("rst_release_ready", int'(bus.blk_ready), 0);
          for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("post_rst_ready", int'(bus.blk_ready), 1);
            check("post_rst_valid", int'(bus.out_valid), 0);
          end
          return;
        end
        if (beats == busy_wr) begin
          bus.qt_wr_en = 1'b1;
          bus.qt_addr  = 6'd63;
          bus.qt_data  = 17'd4096;
        end
        if (beats == stall_idx) begin
          bus.out_ready = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            cyc++;
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_idx", int'(bus.out_idx), beats);
            check("stall_coef", int'($signed(bus.out_coef)), expq[zz[beats]]);
          end
          bus.out_ready = 1'b1;
        end
        beats++;
      end
    end
    check("beat_count", beats, 64);
    @(negedge clock);
    check("valid_after_last", int'(bus.out_valid), 0);
    check("ready_after_drain", int'(bus.blk_ready), 1);
  endtask

  initial begin
    int n;
    bus.blk_valid = 1'b0;
    bus.blk_coef  = '0;
    bus.qt_wr_en  = 1'b0;
    bus.qt_addr   = '0;
    bus.qt_data   = '0;
    bus.out_ready = 1'b1;

    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = 7; r >= 0; r--) if (s - r >= 0 && s - r < 8) begin zz[n] = r*8 + (s - r); n++; end
      end else begin
        for (int r = 0; r < 8; r++) if (s - r >= 0 && s - r < 8) begin zz[n] = r*8 + (s - r); n++; end
      end
    end

    #3;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_coef", int'($signed(bus.out_coef)), 0);
    check("reset_out_idx", int'(bus.out_idx), 0);
    check("reset_out_last", int'(bus.out_last), 0);
    check("reset_blk_ready", int'(bus.blk_ready), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("release_blk_ready", int'(bus.blk_ready), 0);
    @(negedge clock);
    check("first_clock_blk_ready", int'(bus.blk_ready), 1);

    for (int p = 0; p < 64; p++) write_qt(p, 65536);

    for (int p = 0; p < 64; p++) blk[p] = p;
    run_block(-1, -1, -1, 0, -1, 1'b1);
    check("ramp_last_value", got[63], 63);

    for (int p = 0; p < 64; p++) blk[p] = 0;
    blk[0] = 24; blk[1] = -20; blk[2] = -24; blk[3] = 7;
    for (int p = 0; p < 4; p++) write_qt(p, 4096);
    run_block(-1, -1, -1, 0, -1, 1'b1);
    check("round_24", got[0], 2);
    check("round_m20", got[1], -1);
    check("round_m24", got[2], -2);
    check("round_7", got[3], 0);

    for (int p = 0; p < 64; p++) blk[p] = 0;
    blk[0] = -128; blk[1] = 127; blk[2] = 127; blk[3] = 100; blk[4] = -100;
    write_qt(0, 65536); write_qt(1, 65536); write_qt(2, 257);
    write_qt(3, 131071); write_qt(4, 131071);
    run_block(-1, -1, -1, 0, -1, 1'b1);
    check("q1_m128", got[0], -128);
    check("q1_127", got[1], 127);
    check("q255_127", got[2], 0);
    check("sat_pos", got[3], 127);
    check("sat_neg", got[4], -128);

    for (int p = 0; p < 64; p++) write_qt(p, 65536);
    for (int p = 0; p < 64; p++) blk[p] = p;
    run_block(10, -1, -1, 0, -1, 1'b0);

    for (int p = 0; p < 64; p++) blk[p] = 0;
    blk[0] = 100; blk[63] = 100;
    run_block(-1, 10, -1, 0, -1, 1'b1);
    check("busy_write_ignored", got[63], 100);
    run_block(-1, -1, 0, 4096, -1, 1'b1);
    check("accept_write_used", got[0], 6);
    check("busy_write_stays_out", got[63], 100);

    for (int p = 0; p < 64; p++) blk[p] = p;
    run_block(-1, -1, -1, 0, 30, 1'b1);
    run_block(-1, -1, -1, 0, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
